// File: rtl/sample_sched_10hz_if.sv
// Sensor-mux handshake bundle: four-phase REQ/ACK plus the requested channel.
// The scheduler drives REQ/CH (master); the sensor mux answers with ACK (slave).
interface sample_sched_10hz_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  logic            sample_req;
  logic [CH_W-1:0] sample_ch;
  logic            sample_ack;

  modport master (
    output sample_req,
    output sample_ch,
    input  sample_ack
  );

  modport slave (
    input  sample_req,
    input  sample_ch,
    output sample_ack
  );
endinterface

// File: rtl/sample_sched_10hz.sv
// 10 Hz frame scheduler: each rising edge of the divided clock (treated as data)
// polls every sensor channel once over a four-phase handshake with a per-channel timeout.
module sample_sched_10hz #(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int FRAME_W     = 16
) (
  input  logic                     clk_1mhz_in,
  input  logic                     nsysreset,
  input  logic                     clk_10hz_in,
  input  logic                     err_clr,
  sample_sched_10hz_if.master      sensor,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic [FRAME_W-1:0]       frame_cnt,
  output logic [NUM_CH-1:0]        timeout_mask,
  output logic                     overrun,
  output logic                     busy
);

  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]      TIMER_INC  = TW'(1);
  localparam logic [TW-1:0]      TIMER_ZERO = TW'(0);
  localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]    CH_INC     = CH_W'(1);
  localparam logic [CH_W-1:0]    CH_ZERO    = CH_W'(0);
  localparam logic [FRAME_W-1:0] CNT_INC    = FRAME_W'(1);
  localparam logic [FRAME_W-1:0] CNT_ZERO   = FRAME_W'(0);
  localparam logic [NUM_CH-1:0]  MASK_ZERO  = {NUM_CH{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_ACK_LOW = 3'd2,
    S_NEXT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CH_W-1:0]     ch_r;
  logic [CH_W-1:0]     ch_nxt_s;
  logic [TW-1:0]       timer_r;
  logic [TW-1:0]       timer_nxt_s;
  logic [NUM_CH-1:0]   mask_r;
  logic [NUM_CH-1:0]   mask_nxt_s;
  logic                s1_r;
  logic                s2_r;
  logic                s3_r;
  logic                tick_s;
  logic                frame_start_r;
  logic                frame_done_r;
  logic [FRAME_W-1:0]  frame_cnt_r;
  logic [NUM_CH-1:0]   timeout_mask_r;
  logic                overrun_r;

  // Bits from_ch..NUM_CH-1 set: every channel not yet answered when ACK sticks high.
  function automatic logic [NUM_CH-1:0] tail_mask(input logic [CH_W-1:0] from_ch);
    logic [NUM_CH-1:0] m;
    m = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      m[i] = (i >= int'(from_ch));
    end
    return m;
  endfunction

  // Synchronize the divided clock and keep one history flop for edge detection.
  always_ff @(posedge clk_1mhz_in) begin
    if (!nsysreset) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
      s3_r <= 1'b1;
    end else begin
      s1_r <= clk_10hz_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Preset-to-one history means a level already high at reset release is not an edge.
  assign tick_s = s2_r & ~s3_r;

  // FSM state, channel index, handshake timer and working timeout mask.
  always_ff @(posedge clk_1mhz_in) begin
    if (!nsysreset) begin
      state_r <= S_IDLE;
      ch_r    <= CH_ZERO;
      timer_r <= TIMER_ZERO;
      mask_r  <= MASK_ZERO;
    end else begin
      state_r <= state_nxt_s;
      ch_r    <= ch_nxt_s;
      timer_r <= timer_nxt_s;
      mask_r  <= mask_nxt_s;
    end
  end

  // Next-state and datapath decode for the per-channel handshake walk.
  always_comb begin
    state_nxt_s = state_r;
    ch_nxt_s    = ch_r;
    timer_nxt_s = timer_r;
    mask_nxt_s  = mask_r;
    case (state_r)
      S_IDLE: begin
        if (tick_s) begin
          ch_nxt_s    = CH_ZERO;
          timer_nxt_s = TIMER_ZERO;
          mask_nxt_s  = MASK_ZERO;
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        // The timer spans REQ and ACK_LOW together, so it keeps counting on ACK.
        if (sensor.sample_ack) begin
          timer_nxt_s = timer_r + TIMER_INC;
          state_nxt_s = S_ACK_LOW;
        end else if (timer_r == TIMER_LAST) begin
          mask_nxt_s  = mask_r | (MASK_ZERO | (1 << ch_r));
          state_nxt_s = S_NEXT;
        end else begin
          timer_nxt_s = timer_r + TIMER_INC;
        end
      end
      S_ACK_LOW: begin
        if (!sensor.sample_ack) begin
          state_nxt_s = S_NEXT;
        end else if (timer_r == TIMER_LAST) begin
          mask_nxt_s  = mask_r | tail_mask(ch_r);
          state_nxt_s = S_DONE;
        end else begin
          timer_nxt_s = timer_r + TIMER_INC;
        end
      end
      S_NEXT: begin
        timer_nxt_s = TIMER_ZERO;
        if (ch_r == CH_LAST) begin
          state_nxt_s = S_DONE;
        end else begin
          ch_nxt_s    = ch_r + CH_INC;
          state_nxt_s = S_REQ;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Registered frame pulses, published mask, frame counter and sticky overrun.
  always_ff @(posedge clk_1mhz_in) begin
    if (!nsysreset) begin
      frame_start_r  <= 1'b0;
      frame_done_r   <= 1'b0;
      frame_cnt_r    <= CNT_ZERO;
      timeout_mask_r <= MASK_ZERO;
      overrun_r      <= 1'b0;
    end else begin
      frame_start_r <= (state_r == S_IDLE) && tick_s;
      frame_done_r  <= (state_nxt_s == S_DONE);
      if (state_r == S_DONE) begin
        frame_cnt_r    <= frame_cnt_r + CNT_INC;
        timeout_mask_r <= mask_r;
      end else begin
        frame_cnt_r    <= frame_cnt_r;
        timeout_mask_r <= timeout_mask_r;
      end
      // A tick outside IDLE is dropped but remembered; it beats a same-cycle clear.
      if (tick_s && (state_r != S_IDLE)) begin
        overrun_r <= 1'b1;
      end else if (err_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign sensor.sample_req = (state_r == S_REQ);
  assign sensor.sample_ch  = ch_r;
  assign busy              = (state_r != S_IDLE);
  assign frame_start       = frame_start_r;
  assign frame_done        = frame_done_r;
  assign frame_cnt         = frame_cnt_r;
  assign timeout_mask      = timeout_mask_r;
  assign overrun           = overrun_r;

endmodule

// File: tb/tb_sample_sched_10hz.sv
// Directed bench for sample_sched_10hz: NUM_CH=4, TIMEOUT_CYC=16, scripted sensor responder.
module tb_sample_sched_10hz;

  logic        clk = 1'b0;
  logic        nsysreset;
  logic        tick_in;
  logic        err_clr;
  logic        frame_start;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [3:0]  timeout_mask;
  logic        overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // responder modes: 0 prompt, 1 ch2 silent, 2 ack stuck from ch1, 3 never ack
  int   mode = 0;
  logic stuck = 1'b0;

  int cyc = 0;
  int start_cnt, done_cnt, start_cyc, done_cyc;
  int req_cnt [4];
  int visits [$];
  logic prev_req = 1'b0;
  logic start_req;

  sample_sched_10hz_if #(.NUM_CH(4)) sif ();

  sample_sched_10hz #(.NUM_CH(4), .TIMEOUT_CYC(16), .FRAME_W(16)) dut (
    .clk_1mhz_in  (clk),
    .nsysreset    (nsysreset),
    .clk_10hz_in  (tick_in),
    .err_clr      (err_clr),
    .sensor       (sif.master),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .timeout_mask (timeout_mask),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Sensor responder: reacts to the state seen just after each rising edge.
  initial begin
    sif.sample_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 2) begin
        if (sif.sample_req && (sif.sample_ch >= 2'd1)) stuck = 1'b1;
        sif.sample_ack = stuck | sif.sample_req;
      end else begin
        stuck = 1'b0;
        if (mode == 0)      sif.sample_ack = sif.sample_req;
        else if (mode == 1) sif.sample_ack = sif.sample_req && (sif.sample_ch != 2'd2);
        else                sif.sample_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (sif.sample_req && !prev_req) visits.push_back(int'(sif.sample_ch));
    if (sif.sample_req) req_cnt[sif.sample_ch]++;
    if (frame_start) begin
      start_cnt++;
      start_cyc = cyc;
      start_req = sif.sample_req;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_req = sif.sample_req;
  endtask

  task automatic clr_stats();
    start_cnt = 0;
    done_cnt  = 0;
    start_cyc = 0;
    done_cyc  = 0;
    start_req = 1'b0;
    for (int i = 0; i < 4; i++) req_cnt[i] = 0;
    visits.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == 0) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n;
    n = 0;
    while (start_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    if (start_cnt == 0) chk({tag, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    nsysreset = 1'b0;
    tick_in   = 1'b1;
    err_clr   = 1'b0;
    clr_stats();

    // reset with the divided clock held high
    repeat (3) step();
    chk("rst_req", 32'(sif.sample_req), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    nsysreset = 1'b1;
    repeat (12) step();
    chk("rst_start", 32'(start_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ch", 32'(sif.sample_ch), 32'd0);
    chk("rst_mask", 32'(timeout_mask), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    tick_in = 1'b0;
    repeat (5) step();

    // all channels answer promptly: 13-cycle frame
    mode = 0;
    clr_stats();
    tick_in = 1'b1;
    wait_done("ok", 60);
    chk("ok_nvisit", 32'(visits.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < visits.size()) chk("ok_visit", 32'(visits[i]), 32'(i));
    end
    chk("ok_req_at_start", 32'(start_req), 32'd1);
    chk("ok_len", 32'(done_cyc - start_cyc + 1), 32'd13);
    step();
    chk("ok_done_pulse", 32'(frame_done), 32'd0);
    chk("ok_busy", 32'(busy), 32'd0);
    chk("ok_cnt", 32'(frame_cnt), 32'd1);
    chk("ok_mask", 32'(timeout_mask), 32'b0000);
    chk("ok_nstart", 32'(start_cnt), 32'd1);
    tick_in = 1'b0;
    repeat (20) step();

    // channel 2 silent: REQ held 16 cycles, channel 3 still polled
    mode = 1;
    clr_stats();
    tick_in = 1'b1;
    wait_done("sil", 100);
    chk("sil_req2", 32'(req_cnt[2]), 32'd16);
    chk("sil_req3", 32'(req_cnt[3]), 32'd1);
    chk("sil_len", 32'(done_cyc - start_cyc + 1), 32'd27);
    step();
    chk("sil_mask", 32'(timeout_mask), 32'b0100);
    chk("sil_cnt", 32'(frame_cnt), 32'd2);
    tick_in = 1'b0;
    repeat (20) step();

    // ACK stuck high from channel 1 onward
    mode = 2;
    clr_stats();
    tick_in = 1'b1;
    wait_done("stk", 100);
    chk("stk_len", 32'(done_cyc - start_cyc + 1), 32'd20);
    chk("stk_req2", 32'(req_cnt[2]), 32'd0);
    mode = 0;
    step();
    chk("stk_mask", 32'(timeout_mask), 32'b1110);
    chk("stk_busy", 32'(busy), 32'd0);
    chk("stk_cnt", 32'(frame_cnt), 32'd3);
    tick_in = 1'b0;
    repeat (20) step();

    // overrun during a slow frame, clear, then clear colliding with a new overrun
    mode = 3;
    clr_stats();
    tick_in = 1'b1;
    wait_start("ovr", 20);
    tick_in = 1'b0;
    repeat (10) step();
    tick_in = 1'b1;
    repeat (5) step();
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_nstart", 32'(start_cnt), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    chk("ovr_clr", 32'(overrun), 32'd0);
    tick_in = 1'b0;
    repeat (3) step();
    tick_in = 1'b1;
    step();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    chk("ovr_nstart2", 32'(start_cnt), 32'd1);
    wait_done("ovr", 120);
    step();
    chk("ovr_mask", 32'(timeout_mask), 32'b1111);
    chk("ovr_cnt", 32'(frame_cnt), 32'd4);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    chk("ovr_clr2", 32'(overrun), 32'd0);
    tick_in = 1'b0;
    repeat (10) step();

    // counter wrap from 0xFFFF
    mode = 0;
    force dut.frame_cnt_r = 16'hFFFF;
    step();
    release dut.frame_cnt_r;
    step();
    clr_stats();
    tick_in = 1'b1;
    wait_done("wrap", 60);
    step();
    chk("wrap_cnt", 32'(frame_cnt), 32'h0000);
    tick_in = 1'b0;
    repeat (10) step();

    // reset in the middle of a frame
    mode = 3;
    clr_stats();
    tick_in = 1'b1;
    wait_start("mrst", 20);
    repeat (2) step();
    chk("mrst_req_before", 32'(sif.sample_req), 32'd1);
    nsysreset = 1'b0;
    step();
    chk("mrst_req", 32'(sif.sample_req), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    nsysreset = 1'b1;
    repeat (10) step();
    chk("mrst_ndone", 32'(done_cnt), 32'd0);
    chk("mrst_cnt", 32'(frame_cnt), 32'd0);
    chk("mrst_nstart", 32'(start_cnt), 32'd1);
    tick_in = 1'b0;
    mode = 0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_sched_10hz.md
# sample_sched_10hz

Frame scheduler that consumes the 10 Hz output of the 1 MHz→10 Hz clock divider and turns each rising edge into one sampling frame. Each frame polls NUM_CH sensor channels in order over a four-phase REQ/ACK handshake, with a per-channel timeout. It counts completed frames and flags overruns. It runs entirely in the 1 MHz domain and treats the divided clock as a data input, never as a clock.

## Interface
- NUM_CH, 4: channels polled per frame, 2..16.
- TIMEOUT_CYC, 1000: cycles allowed per channel handshake (1 ms at 1 MHz), ≥4.
- FRAME_W, 16: FRAME_CNT width.
- CLK_1MHZ_IN  in  1  system clock; all logic on its rising edge.
- NSYSRESET  in  1  reset, synchronous, active-low.
- CLK_10HZ_IN  in  1  divider output; rising edge starts a frame.
- SAMPLE_ACK  in  1  sensor acknowledge (four-phase).
- ERR_CLR  in  1  clears OVERRUN (level, sampled each cycle).
- SAMPLE_REQ  out  1  request to sensor mux.
- SAMPLE_CH  out  max(1,ceil(log2 NUM_CH))  channel being requested.
- FRAME_START  out  1  one-cycle pulse at frame begin.
- FRAME_DONE  out  1  one-cycle pulse at frame end.
- FRAME_CNT  out  FRAME_W  completed frames, wraps.
- TIMEOUT_MASK  out  NUM_CH  bit i = channel i timed out in last completed frame.
- OVERRUN  out  1  sticky: a 10 Hz edge arrived while a frame was running.
- BUSY  out  1  high whenever FSM ≠ IDLE.

## Operation
- Input conditioning: CLK_10HZ_IN goes through a 2-flop synchronizer (s1, s2) and a history flop s3. TICK = s2 & ~s3. Reset loads s1..s3 = 1, so an input that is high at reset release does not create a tick.
- FSM states are IDLE, REQ, ACK_LOW, NEXT and DONE.
- IDLE:
  - On TICK: ch←0, working mask←0, timer←0, go to REQ.
  - FRAME_START pulses in the first REQ cycle.
- REQ: SAMPLE_REQ=1, SAMPLE_CH=ch.
  - SAMPLE_ACK=1: timer keeps running, go to ACK_LOW.
  - Else if timer==TIMEOUT_CYC-1: set mask[ch], go to NEXT.
  - Else timer++.
- ACK_LOW: SAMPLE_REQ=0.
  - SAMPLE_ACK=0: go to NEXT.
  - Else if timer==TIMEOUT_CYC-1 (ACK stuck high): set mask[ch..NUM_CH-1], go to DONE.
  - Else timer++.
- NEXT: timer←0.
  - If ch==NUM_CH-1, go to DONE.
  - Else ch++, go to REQ.
- DONE: FRAME_DONE=1, TIMEOUT_MASK←working mask, FRAME_CNT++ (modulo 2^FRAME_W), go to IDLE.
- Overrun: a TICK while FSM≠IDLE (DONE included) sets OVERRUN and is discarded. It never restarts or extends the current frame. If set and ERR_CLR occur in the same cycle, set wins.
- SAMPLE_CH holds its last value outside REQ. The downstream mux only qualifies it with SAMPLE_REQ.
- Reset, when NSYSRESET=0 at a clock edge:
  - FSM←IDLE.
  - All outputs 0: SAMPLE_REQ, SAMPLE_CH, FRAME_START, FRAME_DONE, FRAME_CNT, TIMEOUT_MASK, OVERRUN, BUSY.
  - Timer and ch cleared.
  - Reset mid-frame drops SAMPLE_REQ on the next edge. No FRAME_DONE and no count increment.

## Timing
- Input edge to TICK: CLK_10HZ_IN sampled high at edge k → TICK true during cycle k+2.
- TICK in cycle t → FRAME_START and SAMPLE_REQ high in cycle t+1.
- A zero-latency responder costs 3 cycles per channel (REQ, ACK_LOW, NEXT). Full frame with all channels answering is 3·NUM_CH+1 cycles from first REQ to FRAME_DONE inclusive. That is 13 cycles for NUM_CH=4.
- Silent channel: REQ is held exactly TIMEOUT_CYC cycles, then NEXT.
- Worst-case frame is NUM_CH·(TIMEOUT_CYC+1)+1 cycles. Integration must keep this below 100000 (the 10 Hz period); defaults give 4005.
- Outputs are registered except SAMPLE_REQ, SAMPLE_CH and BUSY, which are decoded from registered state only. None depends combinationally on inputs.

## Test plan
Bench uses NUM_CH=4, TIMEOUT_CYC=16 and a 100-cycle stand-in period on CLK_10HZ_IN.
- Reset with CLK_10HZ_IN held high, release, hold high → no FRAME_START, all outputs 0, BUSY=0.
- Responder acks 1 cycle after REQ and drops ack 1 cycle after REQ falls:
  - SAMPLE_CH visits 0,1,2,3.
  - FRAME_DONE comes 1 cycle after the last NEXT.
  - FRAME_CNT=1 and TIMEOUT_MASK=0000.
- Channel 2 never acks → REQ on ch2 high exactly 16 cycles, then TIMEOUT_MASK=0100, and channel 3 is still polled.
- ACK stuck high from channel 1 onward → after timeout, TIMEOUT_MASK=1110, FRAME_DONE pulses, FSM returns to IDLE.
- Second rising edge while a slow frame runs → OVERRUN=1 with no extra FRAME_START. Raising ERR_CLR alone clears it; ERR_CLR in the same cycle as a new overrun leaves it 1.
- Preload FRAME_CNT to 0xFFFF via 65535 frames (or a forced bench value), run 1 frame → FRAME_CNT=0x0000. Then assert NSYSRESET=0 mid-frame → REQ low next edge, no FRAME_DONE.
